port_arbiter: RTL and testbench

Round-robin scheduler that shares the single output data buffer between the four input ports. Each port raises a level request when it holds a packet. The arbiter grants one port at a time and issues the buffer write (`wr_data`, `select`, one-hot `clear_data_available`). It then waits for the buffer to fill and drain before granting again. It replaces first-come ordering with fair, maskable arbitration and adds a watchdog on the buffer handshake.

---
 rtl/port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/port_arbiter.sv
// Round-robin arbiter sharing one output buffer between NUM_PORTS requesters,
// with maskable eligibility and a watchdog on the buffer fill/drain handshake.
module port_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] data_available,
  input  logic [NUM_PORTS-1:0] port_mask,
  input  logic                 data_empty,
  input  logic                 err_clear,
  output logic                 wr_data,
  output logic [SEL_W-1:0]     select,
  output logic [NUM_PORTS-1:0] clear_data_available,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    FILL  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [SEL_W-1:0]       last_r, last_s;
  logic [SEL_W-1:0]       sel_r, sel_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   err_set_s;
  logic [NUM_PORTS-1:0]   elig_s;
  logic [SEL_W-1:0]       win_s;

  logic                   wr_data_r;
  logic [SEL_W-1:0]       select_r;
  logic [NUM_PORTS-1:0]   clear_r;
  logic                   busy_r;
  logic                   err_r;

  // First eligible index after `last`, wrapping; returns `last` if none is eligible.
  function automatic logic [SEL_W-1:0] pick_winner(input logic [NUM_PORTS-1:0] elig,
                                                   input logic [SEL_W-1:0]     last);
    logic [SEL_W-1:0] idx;
    logic             found;
    pick_winner = last;
    found       = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = SEL_W'((int'(last) + k) % NUM_PORTS);
      if (!found && elig[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
  endfunction

  // Next-state, pointer, watchdog counter and timeout detection.
  always_comb begin
    elig_s    = data_available & port_mask;
    win_s     = pick_winner(elig_s, last_r);
    state_s   = state_r;
    last_s    = last_r;
    sel_s     = sel_r;
    cnt_s     = cnt_r;
    err_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (|elig_s) begin
          state_s = GRANT;
          sel_s   = win_s;
          last_s  = win_s;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s = FILL;
        cnt_s   = '0;
      end
      FILL: begin
        if (!data_empty) begin
          state_s = DRAIN;
          cnt_s   = '0;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          err_set_s = 1'b1;
          state_s   = IDLE;
          cnt_s     = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (data_empty) begin
          cnt_s = '0;
          // Back-to-back grant when another request is already waiting.
          if (|elig_s) begin
            state_s = GRANT;
            sel_s   = win_s;
            last_s  = win_s;
          end else begin
            state_s = IDLE;
          end
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          err_set_s = 1'b1;
          state_s   = IDLE;
          cnt_s     = '0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= SEL_W'(NUM_PORTS - 1);
      sel_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      sel_r   <= sel_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output registers loaded with the decode of the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_data_r <= 1'b0;
      select_r  <= '0;
      clear_r   <= '0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      wr_data_r <= (state_s == GRANT);
      select_r  <= (state_s == GRANT) ? sel_s : '0;
      clear_r   <= (state_s == GRANT) ? ({{(NUM_PORTS-1){1'b0}}, 1'b1} << sel_s) : '0;
      busy_r    <= (state_s != IDLE);
      if (err_set_s) begin
        err_r <= 1'b1;
      end else if (err_clear) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign wr_data              = wr_data_r;
  assign select               = select_r;
  assign clear_data_available = clear_r;
  assign busy                 = busy_r;
  assign timeout_err          = err_r;

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: directed vector table, hand-written
// watchdog/reset sequences, and randomized traffic against a reference model.
module tb_port_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] da;
  logic [3:0] mask;
  logic       de;
  logic       ec;
  logic       wr_data;
  logic [1:0] select;
  logic [3:0] clear_data_available;
  logic       busy;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  port_arbiter #(.NUM_PORTS(4), .SEL_W(2), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_available       (da),
    .port_mask            (mask),
    .data_empty           (de),
    .err_clear            (ec),
    .wr_data              (wr_data),
    .select               (select),
    .clear_data_available (clear_data_available),
    .busy                 (busy),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  // Packed observation: {wr_data, select, clear, busy, timeout_err}
  function automatic logic [8:0] e_idle(input logic err);
    return {1'b0, 2'd0, 4'd0, 1'b0, err};
  endfunction
  function automatic logic [8:0] e_busy(input logic err);
    return {1'b0, 2'd0, 4'd0, 1'b1, err};
  endfunction
  function automatic logic [8:0] e_grant(input int p, input logic err);
    logic [3:0] one;
    one = 4'b0001;
    return {1'b1, p[1:0], one << p, 1'b1, err};
  endfunction

  function automatic logic [8:0] observe();
    return {wr_data, select, clear_data_available, busy, timeout_err};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got wr=%b sel=%0d clr=%b busy=%b err=%b, want wr=%b sel=%0d clr=%b busy=%b err=%b",
               nm, act[8], act[7:6], act[5:2], act[1], act[0],
               exp[8], exp[7:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; da = 4'd0; mask = 4'hF; de = 1'b1; ec = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] da;
    logic [3:0] mask;
    logic       de;
    logic       ec;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [3:0] a, input logic [3:0] m,
                              input logic d, input logic c, input logic [8:0] x);
    vec_t v;
    v.rst = r; v.da = a; v.mask = m; v.de = d; v.ec = c; v.exp = x;
    vecs.push_back(v);
  endfunction

  // Reference model: abstract phase + wait counter, rotating-priority winner.
  int m_ph, m_last, m_sel, m_wait;
  logic m_err;

  function automatic int m_winner(input logic [3:0] elig);
    for (int k = 1; k <= 4; k++) begin
      if (elig[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ph = 0; m_last = 3; m_sel = 0; m_wait = 0; m_err = 1'b0;
  endtask

  task automatic m_step(input logic [3:0] a, input logic [3:0] m, input logic d, input logic c);
    logic [3:0] elig;
    logic tmo;
    elig = a & m;
    tmo  = 1'b0;
    if (m_ph == 0 || (m_ph == 3 && d)) begin
      if (elig != 4'd0) begin
        m_sel = m_winner(elig); m_last = m_sel; m_ph = 1;
      end else begin
        m_ph = 0;
      end
    end else if (m_ph == 1) begin
      m_ph = 2; m_wait = 0;
    end else if (m_ph == 2 && !d) begin
      m_ph = 3; m_wait = 0;
    end else if (m_wait == TIMEOUT - 1) begin
      tmo = 1'b1; m_ph = 0;
    end else begin
      m_wait++;
    end
    if (tmo) m_err = 1'b1;
    else if (c) m_err = 1'b0;
  endtask

  function automatic logic [8:0] m_exp();
    if (m_ph == 1) return e_grant(m_sel, m_err);
    if (m_ph == 0) return e_idle(m_err);
    return e_busy(m_err);
  endfunction

  initial begin
    int order[4];
    int mode;
    logic [3:0] a, m;
    logic d, c;

    rst = 1'b1; da = 4'd0; mask = 4'hF; de = 1'b1; ec = 1'b0;
    #1;
    chk("reset_async_initial", observe(), e_idle(1'b0));

    // Single request with fill/drain
    add(1'b1, 4'b0000, 4'hF, 1'b1, 1'b0, e_idle(1'b0));
    add(1'b0, 4'b0100, 4'hF, 1'b1, 1'b0, e_grant(2, 1'b0));
    add(1'b0, 4'b0000, 4'hF, 1'b1, 1'b0, e_busy(1'b0));
    add(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0, e_busy(1'b0));
    add(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0, e_busy(1'b0));
    add(1'b0, 4'b0000, 4'hF, 1'b0, 1'b0, e_busy(1'b0));
    add(1'b0, 4'b0000, 4'hF, 1'b1, 1'b0, e_idle(1'b0));
    // Fairness: 0,1,2,3,0,1 back to back
    add(1'b1, 4'b0000, 4'hF, 1'b1, 1'b0, e_idle(1'b0));
    for (int g = 0; g < 6; g++) begin
      add(1'b0, 4'hF, 4'hF, 1'b1, 1'b0, e_grant(g % 4, 1'b0));
      add(1'b0, 4'hF, 4'hF, 1'b1, 1'b0, e_busy(1'b0));
      add(1'b0, 4'hF, 4'hF, 1'b0, 1'b0, e_busy(1'b0));
    end
    // Masking: port 2 excluded, order 0,1,3,0
    order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;
    add(1'b1, 4'b0000, 4'hF, 1'b1, 1'b0, e_idle(1'b0));
    for (int g = 0; g < 4; g++) begin
      add(1'b0, 4'hF, 4'b1011, 1'b1, 1'b0, e_grant(order[g], 1'b0));
      add(1'b0, 4'hF, 4'b1011, 1'b1, 1'b0, e_busy(1'b0));
      add(1'b0, 4'hF, 4'b1011, 1'b0, 1'b0, e_busy(1'b0));
    end

    foreach (vecs[i]) begin
      rst = vecs[i].rst; da = vecs[i].da; mask = vecs[i].mask;
      de = vecs[i].de; ec = vecs[i].ec;
      tick();
      chk($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Watchdog in FILL
    do_reset();
    da = 4'b0001; de = 1'b1;
    tick(); chk("wd_fill_grant", observe(), e_grant(0, 1'b0));
    da = 4'b0000;
    tick();
    repeat (15) tick();
    chk("wd_fill_before", observe(), e_busy(1'b0));
    tick(); chk("wd_fill_timeout", observe(), e_idle(1'b1));
    ec = 1'b1; tick(); ec = 1'b0;
    chk("wd_fill_clear", observe(), e_idle(1'b0));

    // Watchdog in DRAIN, with err_clear colliding with the timeout
    da = 4'b0010; de = 1'b1;
    tick(); chk("wd_drain_grant", observe(), e_grant(1, 1'b0));
    da = 4'b0000;
    tick();
    de = 1'b0;
    tick();
    repeat (15) tick();
    chk("wd_drain_before", observe(), e_busy(1'b0));
    ec = 1'b1; tick(); ec = 1'b0;
    chk("wd_set_wins", observe(), e_idle(1'b1));
    ec = 1'b1; tick(); ec = 1'b0;
    chk("wd_drain_clear", observe(), e_idle(1'b0));

    // Reset during DRAIN
    do_reset();
    da = 4'b1010; de = 1'b1;
    tick(); chk("rst_mid_grant", observe(), e_grant(1, 1'b0));
    tick();
    de = 1'b0;
    tick(); chk("rst_mid_drain", observe(), e_busy(1'b0));
    rst = 1'b1;
    #1;
    chk("rst_mid_async", observe(), e_idle(1'b0));
    #2;
    rst = 1'b0; da = 4'hF; de = 1'b1;
    tick(); chk("rst_mid_regrant", observe(), e_grant(0, 1'b0));

    // Randomized traffic against the reference model
    do_reset();
    m_reset();
    for (int i = 0; i < 900; i++) begin
      mode = (i / 100) % 3;
      a = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (mode == 0)      d = 1'($urandom_range(0, 1));
      else if (mode == 1) d = ($urandom_range(0, 31) != 0);
      else                d = ($urandom_range(0, 31) == 0);
      c = ($urandom_range(0, 15) == 0);
      da = a; mask = m; de = d; ec = c;
      m_step(a, m, d, c);
      tick();
      chk($sformatf("rand%0d", i), observe(), m_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
